// File: rtl/digital_safe_seq.sv
// Multi-digit code safe with failed-attempt lockout, auto-relock and a 7-segment status display.
// Define SAFE_CODE_PROG_EN to allow reprogramming the code while the safe is open.
module digital_safe_seq #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h75BA,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned OPEN_CYCLES    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               clear,
  input  logic               relock,
  input  logic               prog,
  output logic               unlocked,
  output logic               locked_out,
  output logic               prog_done,
  output logic [6:0]         display
);

  localparam int unsigned CodeW    = CODE_LEN * DIGIT_W;
  localparam int unsigned IdxW     = $clog2(CODE_LEN + 1);
  localparam int unsigned FailW    = $clog2(MAX_TRIES + 1);
  localparam int unsigned LockTmrW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned OpenTmrW = (OPEN_CYCLES > 0) ? $clog2(OPEN_CYCLES + 1) : 1;
  localparam int unsigned OpenLast = (OPEN_CYCLES > 0) ? OPEN_CYCLES - 1 : 0;

  localparam logic [6:0] SegU = 7'b0111110;
  localparam logic [6:0] SegE = 7'b1111001;
  localparam logic [6:0] SegL = 7'b0111000;

  typedef enum logic [1:0] {StEntry, StFail, StLockout, StOpen} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  mism_q, mism_d;
  logic [FailW-1:0]      fail_q, fail_d;
  logic [LockTmrW-1:0]   lock_tmr_q, lock_tmr_d;
  logic [OpenTmrW-1:0]   open_tmr_q, open_tmr_d;
  logic [CodeW-1:0]      code;
  logic [DIGIT_W-1:0]    exp_digit;
  logic                  digit_bad;
  logic                  open_timeout;

`ifdef SAFE_CODE_PROG_EN
  logic [CodeW-1:0]      code_q, code_d;
  logic [CodeW-1:0]      shadow_q, shadow_d;
  logic [IdxW-1:0]       pidx_q, pidx_d;
  logic                  prog_done_q, prog_done_d;

  assign code      = code_q;
  assign prog_done = prog_done_q;
`else
  logic                  unused_prog;

  assign code        = DEFAULT_CODE;
  assign prog_done   = 1'b0;
  assign unused_prog = prog;
`endif

  function automatic logic [6:0] seg_digit(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // First code digit lives in the most significant digit slot.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (idx_q == IdxW'(i)) begin
        exp_digit = code[DIGIT_W*(CODE_LEN-1-i) +: DIGIT_W];
      end
    end
  end

  assign digit_bad    = (digit != exp_digit);
  assign open_timeout = (OPEN_CYCLES > 0) && (open_tmr_q == OpenTmrW'(OpenLast));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mism_d     = mism_q;
    fail_d     = fail_q;
    lock_tmr_d = lock_tmr_q;
    open_tmr_d = open_tmr_q;
`ifdef SAFE_CODE_PROG_EN
    code_d      = code_q;
    shadow_d    = shadow_q;
    pidx_d      = pidx_q;
    prog_done_d = 1'b0;
`endif
    unique case (state_q)
      StEntry: begin
        if (clear) begin
          idx_d  = '0;
          mism_d = 1'b0;
        end else if (digit_valid) begin
          if (idx_q == IdxW'(CODE_LEN - 1)) begin
            idx_d  = '0;
            mism_d = 1'b0;
            if (mism_q || digit_bad) begin
              state_d = StFail;
            end else begin
              state_d    = StOpen;
              fail_d     = '0;
              open_tmr_d = '0;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            mism_d = mism_q | digit_bad;
          end
        end
      end
      StFail: begin
        if (fail_q < FailW'(MAX_TRIES)) begin
          fail_d = fail_q + 1'b1;
        end
        if (fail_d == FailW'(MAX_TRIES)) begin
          state_d    = StLockout;
          lock_tmr_d = '0;
        end else begin
          state_d = StEntry;
        end
      end
      StLockout: begin
        if (lock_tmr_q == LockTmrW'(LOCKOUT_CYCLES - 1)) begin
          state_d    = StEntry;
          fail_d     = '0;
          lock_tmr_d = '0;
        end else begin
          lock_tmr_d = lock_tmr_q + 1'b1;
        end
      end
      StOpen: begin
        if (relock || open_timeout) begin
          state_d    = StEntry;
          open_tmr_d = '0;
`ifdef SAFE_CODE_PROG_EN
          pidx_d     = '0;
`endif
        end else begin
          if (OPEN_CYCLES > 0) begin
            open_tmr_d = open_tmr_q + 1'b1;
          end
`ifdef SAFE_CODE_PROG_EN
          if (digit_valid && prog) begin
            shadow_d   = (shadow_q << DIGIT_W) | CodeW'(digit);
            open_tmr_d = '0;
            if (pidx_q == IdxW'(CODE_LEN - 1)) begin
              code_d      = shadow_d;
              prog_done_d = 1'b1;
              pidx_d      = '0;
            end else begin
              pidx_d = pidx_q + 1'b1;
            end
          end
`endif
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StEntry;
      idx_q      <= '0;
      mism_q     <= 1'b0;
      fail_q     <= '0;
      lock_tmr_q <= '0;
      open_tmr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mism_q     <= mism_d;
      fail_q     <= fail_d;
      lock_tmr_q <= lock_tmr_d;
      open_tmr_q <= open_tmr_d;
    end
  end

`ifdef SAFE_CODE_PROG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '0;
      pidx_q      <= '0;
      prog_done_q <= 1'b0;
    end else begin
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      pidx_q      <= pidx_d;
      prog_done_q <= prog_done_d;
    end
  end
`endif

  assign unlocked   = (state_q == StOpen);
  assign locked_out = (state_q == StLockout);

  always_comb begin
    display = seg_digit(4'(idx_q));
    unique case (state_q)
      StEntry:   display = seg_digit(4'(idx_q));
      StFail:    display = SegE;
      StLockout: display = SegL;
      StOpen:    display = SegU;
      default:   display = seg_digit(4'd0);
    endcase
  end

endmodule
